// File: rtl/disp_pkg.sv
// disp_pkg: scan FSM states and seven-segment patterns shared by the display scan controller.
package disp_pkg;
  typedef enum logic [1:0] {OFF, DRIVE, BLANK} scan_state_t;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  // Codes 10-15 are not BCD and show nothing.
  localparam logic [6:0] SEG_LUT [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                          SEG_8, SEG_9, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
                                          SEG_BLANK, SEG_BLANK};
endpackage

// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: digit-register write bus of the display scan controller.
interface display_scan_ctrl_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  modport master (output wr_en, wr_addr, wr_data);
  modport slave (input wr_en, wr_addr, wr_data);
endinterface

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: combinational BCD to active-high seven-segment decoder.
module bcd_to_7seg
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb seg = SEG_LUT[bcd];
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed seven-segment scanner with per-digit dwell, anti-ghost blank and leading-zero blanking.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int N_DIGITS     = 3,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                lzb,
  display_scan_ctrl_if.slave  wr,
  output logic [6:0]          seg_out,
  output logic [N_DIGITS-1:0] digit_sel,
  output logic                frame_tick
);
  localparam int IW   = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam int CMAX = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  scan_state_t         state;
  logic [IW-1:0]       idx, ld_idx;
  logic [CW-1:0]       cnt;
  logic [3:0]          digs [N_DIGITS];
  logic [N_DIGITS-1:0] hz;
  logic [6:0]          dec_seg, ld_seg;
  logic                last_idx;
  // ld_idx is the digit the next DRIVE entry will show; its pattern is captured into seg_out then.
  always_comb begin
    last_idx = idx == IW'(N_DIGITS - 1);
    ld_idx = (state == OFF || last_idx) ? '0 : idx + 1'b1;
    hz = '1;
    for (int k = 0; k < N_DIGITS; k++)
      for (int j = 0; j < N_DIGITS; j++)
        if (j >= k && digs[j] != 4'd0) hz[k] = 1'b0;
    ld_seg = (lzb && ld_idx != '0 && hz[ld_idx]) ? SEG_BLANK : dec_seg;
  end
  bcd_to_7seg u_dec (
    .bcd(digs[ld_idx]),
    .seg(dec_seg)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= OFF;
      idx        <= '0;
      cnt        <= '0;
      seg_out    <= SEG_BLANK;
      digit_sel  <= '0;
      frame_tick <= 1'b0;
      for (int i = 0; i < N_DIGITS; i++) digs[i] <= 4'd0;
    end else begin
      for (int i = 0; i < N_DIGITS; i++)
        if (wr.wr_en && wr.wr_addr == 3'(i)) digs[i] <= wr.wr_data;
      frame_tick <= 1'b0;
      if (!enable) begin
        state     <= OFF;
        idx       <= '0;
        cnt       <= '0;
        seg_out   <= SEG_BLANK;
        digit_sel <= '0;
      end else begin
        case (state)
          DRIVE:
            if (cnt == CW'(DWELL_CYCLES - 1)) begin
              state      <= BLANK;
              cnt        <= '0;
              seg_out    <= SEG_BLANK;
              digit_sel  <= '0;
              frame_tick <= BLANK_CYCLES == 1 && last_idx;
            end else cnt <= cnt + 1'b1;
          BLANK:
            if (cnt == CW'(BLANK_CYCLES - 1)) begin
              state     <= DRIVE;
              idx       <= ld_idx;
              cnt       <= '0;
              seg_out   <= ld_seg;
              digit_sel <= N_DIGITS'(1) << ld_idx;
            end else begin
              cnt        <= cnt + 1'b1;
              frame_tick <= cnt == CW'(BLANK_CYCLES - 2) && last_idx;
            end
          default: begin
            state     <= DRIVE;
            idx       <= ld_idx;
            cnt       <= '0;
            seg_out   <= ld_seg;
            digit_sel <= N_DIGITS'(1) << ld_idx;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench comparing the scanner against a frame-position reference model.
module tb_display_scan_ctrl;
  localparam int ND    = 3;
  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = DW + BL;
  localparam int FRAME = ND * SLOT;
  typedef struct packed {
    logic [6:0]    seg;
    logic [ND-1:0] sel;
    logic          tick;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, lzb = 1'b0;
  logic [6:0]    seg_out;
  logic [ND-1:0] digit_sel;
  logic          frame_tick;
  int tests = 0, fails = 0;
  exp_t q[$];
  int   regs [ND];
  bit   on = 1'b0;
  int   t = 0;
  logic [6:0] snap = 7'h00;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  display_scan_ctrl_if wr_if ();
  display_scan_ctrl #(.N_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .lzb(lzb), .wr(wr_if),
    .seg_out(seg_out), .digit_sel(digit_sel), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] shown(input int d, input logic lz);
    bit z = 1'b1;
    for (int k = d; k < ND; k++) if (regs[k] != 0) z = 1'b0;
    if (lz && d != 0 && z) return 7'h00;
    return regs[d] < 10 ? seg_tab[regs[d]] : 7'h00;
  endfunction
  task automatic step(input logic r, input logic en, input logic lz, input logic we,
                      input logic [2:0] wa, input logic [3:0] wd);
    exp_t e = '0;
    int p, d, w;
    @(negedge clk);
    rst = r; enable = en; lzb = lz;
    wr_if.wr_en = we; wr_if.wr_addr = wa; wr_if.wr_data = wd;
    if (r) begin
      on = 1'b0;
      for (int k = 0; k < ND; k++) regs[k] = 0;
    end else if (!en) on = 1'b0;
    else begin
      t = on ? t + 1 : 0;
      on = 1'b1;
      p = t % FRAME; d = p / SLOT; w = p % SLOT;
      if (w == 0) snap = shown(d, lz);
      e.sel = w < DW ? ND'(1 << d) : '0;
      e.seg = w < DW ? snap : 7'h00;
      e.tick = p == FRAME - 1;
    end
    if (!r && we && wa < ND) regs[wa] = int'(wd);
    q.push_back(e);
  endtask
  task automatic run(input int n, input logic lz);
    repeat (n) step(1'b0, 1'b1, lz, 1'b0, 3'd0, 4'd0);
  endtask
  task automatic wr(input logic en, input logic [2:0] a, input logic [3:0] d);
    step(1'b0, en, lzb, 1'b1, a, d);
  endtask
  // Reset asserted half a cycle away from any edge must clear the outputs immediately.
  task automatic reset_mid();
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (seg_out !== 7'h00 || digit_sel !== '0 || frame_tick !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: seg=%h sel=%b tick=%b, required all zero", seg_out, digit_sel, frame_tick);
    end
    on = 1'b0;
    for (int k = 0; k < ND; k++) regs[k] = 0;
    q.push_back('0);
    step(1'b1, 1'b1, lzb, 1'b0, 3'd0, 4'd0);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (seg_out !== e.seg || digit_sel !== e.sel || frame_tick !== e.tick) begin
          fails++;
          $display("FAIL scan @%0t: seg=%h sel=%b tick=%b, required seg=%h sel=%b tick=%b",
                   $time, seg_out, digit_sel, frame_tick, e.seg, e.sel, e.tick);
        end
      end
    end
  end
  initial begin : driver
    logic lz = 1'b0;
    wr_if.wr_en = 1'b0; wr_if.wr_addr = '0; wr_if.wr_data = '0;
    for (int k = 0; k < ND; k++) regs[k] = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 4'd9);
    wr(1'b0, 3'd0, 4'd1); wr(1'b0, 3'd1, 4'd2); wr(1'b0, 3'd2, 4'd3);
    run(3 * FRAME, 1'b0);
    wr(1'b0, 3'd0, 4'd5); wr(1'b0, 3'd1, 4'd0); wr(1'b0, 3'd2, 4'd0);
    run(FRAME, 1'b1);
    run(FRAME, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    run(1, 1'b0);
    wr(1'b1, 3'd0, 4'd7);
    run(2 * FRAME, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    run(SLOT + 2, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    run(FRAME, 1'b0);
    wr(1'b1, 3'd1, 4'd12);
    wr(1'b1, 3'd5, 4'd9);
    wr(1'b1, 3'd7, 4'd1);
    run(2 * FRAME, 1'b0);
    reset_mid();
    run(FRAME + 3, 1'b0);
    repeat (3000) begin
      if ($urandom_range(0, 31) == 0) lz = ~lz;
      if ($urandom_range(0, 499) == 0) reset_mid();
      else step(1'b0, $urandom_range(0, 63) != 0, lz, $urandom_range(0, 3) == 0,
                3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
